// File: rtl/uart_pkg.sv
// Shared UART definitions: counter width, receiver state encoding and the
// baud-select to bit-time-count table used by both transmit and receive paths.
package uart_pkg;

  localparam int CNT_W = 18;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } rx_state_e;

  function automatic int unsigned baud_rate(input int unsigned sel);
    case (sel)
      0:       return 300;
      1:       return 1200;
      2:       return 2400;
      3:       return 4800;
      4:       return 9600;
      5:       return 19200;
      6:       return 38400;
      7:       return 57600;
      8:       return 115200;
      9:       return 230400;
      10:      return 460800;
      11:      return 921600;
      default: return 115200;
    endcase
  endfunction

  // Bit time in clocks, rounded to nearest; all 16 selects packed into one
  // constant so the select path is a plain mux with no divider.
  function automatic logic [16*CNT_W-1:0] count_table(input int unsigned clk_hz);
    logic [16*CNT_W-1:0] tbl;
    int unsigned         rate;
    tbl = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      rate = baud_rate(i);
      tbl[i*CNT_W +: CNT_W] = CNT_W'((clk_hz + rate / 2) / rate);
    end
    return tbl;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter: after a load, pulses tick once after either a full
// or a half period of clocks, then stops until loaded again.
module uart_bit_timer
  import uart_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             half,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);

  cnt_t cnt_q;
  cnt_t load_val;
  logic run_q;

  assign load_val = half ? {1'b0, period[CNT_W-1:1]} : period;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (load) begin
      cnt_q <= load_val - cnt_t'(1);
      run_q <= 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) run_q <= 1'b0;
      else             cnt_q <= cnt_q - cnt_t'(1);
    end
  end

  assign tick = run_q && (cnt_q == '0);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling of a synchronized rx line, 7/8-bit
// characters with optional parity, and a ready/read host handshake.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       eight,
  input  logic       pen,
  input  logic       ohel,
  input  logic [3:0] baud,
  input  logic       read,
  output logic [7:0] data,
  output logic       rxrdy,
  output logic       perr,
  output logic       ferr,
  output logic       ovf
);

  localparam logic [16*CNT_W-1:0] N_TBL = count_table(CLK_HZ);

  logic [1:0] sync_q;
  logic       rx_s;
  rx_state_e  state_q, state_d;
  logic       armed_q;
  logic [3:0] bit_cnt_q;
  logic [8:0] shift_q;
  logic       eight_q, pen_q, ohel_q;
  cnt_t       n_q, n_sel, period;
  logic       tick, tmr_load, tmr_half, start_det, shift_en, frame_done;
  logic [3:0] nbits;
  logic [8:0] rcv;
  logic [7:0] data_new;
  logic       par_bit, perr_new;

  assign rx_s  = sync_q[1];
  assign n_sel = N_TBL[int'(baud) * CNT_W +: CNT_W];
  assign nbits = 4'd7 + {3'b000, eight_q} + {3'b000, pen_q};

  // Idle-high reset value keeps a low line during reset from looking like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    tmr_load   = 1'b0;
    tmr_half   = 1'b0;
    start_det  = 1'b0;
    shift_en   = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE: if (armed_q && !rx_s) begin
        state_d   = S_START;
        tmr_load  = 1'b1;
        tmr_half  = 1'b1;
        start_det = 1'b1;
      end
      S_START: if (tick) begin
        if (!rx_s) begin
          state_d  = S_DATA;
          tmr_load = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: if (tick) begin
        shift_en = 1'b1;
        tmr_load = 1'b1;
        if (bit_cnt_q == nbits - 4'd1) state_d = S_STOP;
      end
      S_STOP: if (tick) begin
        frame_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign period = start_det ? n_sel : n_q;

  uart_bit_timer u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (tmr_load),
    .half   (tmr_half),
    .period (period),
    .tick   (tick)
  );

  // A start needs a high level seen in IDLE first, so a line stuck low after
  // a framing error does not retrigger until it returns high and falls again.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed_q   <= 1'b0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      eight_q   <= 1'b1;
      pen_q     <= 1'b0;
      ohel_q    <= 1'b0;
      n_q       <= '0;
    end else begin
      if (state_q != S_IDLE) armed_q <= 1'b0;
      else if (rx_s)         armed_q <= 1'b1;
      if (start_det) begin
        eight_q   <= eight;
        pen_q     <= pen;
        ohel_q    <= ohel;
        n_q       <= n_sel;
        bit_cnt_q <= '0;
      end else if (shift_en) begin
        bit_cnt_q <= bit_cnt_q + 4'd1;
      end
      if (shift_en) shift_q <= {rx_s, shift_q[8:1]};
    end
  end

  // After nbits right-shifts the first received bit sits at 9-nbits.
  always_comb begin
    rcv      = shift_q >> (4'd9 - nbits);
    data_new = eight_q ? rcv[7:0] : {1'b0, rcv[6:0]};
    par_bit  = eight_q ? rcv[8] : rcv[7];
    perr_new = pen_q & ((^data_new ^ par_bit) != ohel_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data  <= 8'h00;
      rxrdy <= 1'b0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
      ovf   <= 1'b0;
    end else if (frame_done) begin
      data  <= data_new;
      rxrdy <= 1'b1;
      ferr  <= ~rx_s;
      perr  <= perr_new;
      ovf   <= rxrdy & ~read;
    end else if (read) begin
      rxrdy <= 1'b0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
      ovf   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at baud select 11 (54 clocks per bit):
// directed scenarios followed by random frames against a behavioural model.
module tb_uart_rx;

  localparam int N     = 54;
  localparam int L_REF = 2 + N / 2 + 9 * N;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       rx    = 1'b1;
  logic       eight = 1'b1;
  logic       pen   = 1'b0;
  logic       ohel  = 1'b0;
  logic [3:0] baud  = 4'd11;
  logic       read  = 1'b0;
  logic [7:0] data;
  logic       rxrdy, perr, ferr, ovf;

  int   vectors     = 0;
  int   errors      = 0;
  int   cyc         = 0;
  int   frame_start = 0;
  int   rise_cyc    = -1;
  int   lat         = L_REF;
  logic rdy_prev    = 1'b0;
  logic model_rdy   = 1'b0;

  uart_rx #(.CLK_HZ(50_000_000)) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .eight (eight),
    .pen   (pen),
    .ohel  (ohel),
    .baud  (baud),
    .read  (read),
    .data  (data),
    .rxrdy (rxrdy),
    .perr  (perr),
    .ferr  (ferr),
    .ovf   (ovf)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rxrdy && !rdy_prev) rise_cyc = cyc;
    rdy_prev = rxrdy;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] d, input logic r,
                           input logic p, input logic f, input logic o);
    check({tag, ".data"},  data,  d);
    check({tag, ".rxrdy"}, {7'd0, rxrdy}, {7'd0, r});
    check({tag, ".perr"},  {7'd0, perr},  {7'd0, p});
    check({tag, ".ferr"},  {7'd0, ferr},  {7'd0, f});
    check({tag, ".ovf"},   {7'd0, ovf},   {7'd0, o});
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_read();
    read = 1'b1;
    step(1);
    read = 1'b0;
  endtask

  // Drives start, nb payload bits LSB first, then the stop bit, N clocks each.
  // read_off >= 0 makes read sampled at the edge frame_start + read_off.
  task automatic send_frame(input logic [8:0] payload, input int nb,
                            input logic stop_bit, input int read_off);
    logic v;
    for (int b = 0; b < nb + 2; b++) begin
      v  = (b == 0) ? 1'b0 : (b == nb + 1) ? stop_bit : payload[b-1];
      rx = v;
      if (b == 0) frame_start = cyc;
      repeat (N) begin
        @(posedge clk);
        #1;
        read = (read_off >= 0) && (cyc == frame_start + read_off - 1);
      end
    end
    read = 1'b0;
    rx   = 1'b1;
  endtask

  task automatic send_char(input logic [7:0] v, input logic e, input logic p,
                           input logic o, input logic pbit, input logic stop_bit,
                           input int read_off);
    logic [8:0] payload;
    eight   = e;
    pen     = p;
    ohel    = o;
    payload = e ? {pbit, v} : {1'b0, pbit, v[6:0]};
    send_frame(payload, 7 + int'(e) + int'(p), stop_bit, read_off);
  endtask

  initial begin
    logic [7:0] val, exp_d;
    logic       e, p, o, stop_bit, pbit, exp_perr, exp_ovf;

    step(5);
    check_out("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step(10);
    check_out("post_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    rise_cyc = -1;
    send_char(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    step(8);
    check_out("8n1_a5", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    vectors++;
    assert (rise_cyc >= 0 && rise_cyc - frame_start >= L_REF - 4 && rise_cyc - frame_start <= L_REF + 4)
    else begin
      errors++;
      $error("FAIL latency: observed %0d expected %0d+-4", rise_cyc - frame_start, L_REF);
    end
    if (rise_cyc >= 0 && rise_cyc - frame_start >= L_REF - 4 && rise_cyc - frame_start <= L_REF + 4)
      lat = rise_cyc - frame_start;
    pulse_read();
    step(2);
    check("read_clr.rxrdy", {7'd0, rxrdy}, 8'd0);
    check("read_hold.data", data, 8'hA5);

    send_char(8'h41, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, -1);
    step(8);
    check_out("7e1_bad", 8'h41, 1'b1, 1'b1, 1'b0, 1'b0);
    pulse_read();
    send_char(8'h41, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, -1);
    step(8);
    check_out("7e1_ok", 8'h41, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_read();

    send_char(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    step(8);
    check_out("ferr_3c", 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
    pulse_read();
    step(4);

    rx = 1'b0;
    step(20);
    rx = 1'b1;
    step(200);
    check("false_start.rxrdy", {7'd0, rxrdy}, 8'd0);
    send_char(8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    step(8);
    check_out("after_false_55", 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_read();

    send_char(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    send_char(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    step(8);
    check_out("b2b_ovf", 8'h22, 1'b1, 1'b0, 1'b0, 1'b1);
    pulse_read();
    step(4);
    send_char(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    send_char(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, lat);
    step(8);
    check_out("b2b_read", 8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_read();

    eight = 1'b1;
    pen   = 1'b0;
    rx    = 1'b0;
    step(N);
    rx = 1'b1;
    step(3 * N);
    reset = 1'b0;
    step(3);
    check_out("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step(6 * N);
    send_char(8'h0F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    step(8);
    check_out("after_reset_0f", 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_read();
    model_rdy = 1'b0;

    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        pulse_read();
        model_rdy = 1'b0;
      end
      val      = 8'($urandom);
      e        = 1'($urandom_range(0, 1));
      p        = 1'($urandom_range(0, 1));
      o        = 1'($urandom_range(0, 1));
      stop_bit = ($urandom_range(0, 3) != 0);
      exp_d    = e ? val : {1'b0, val[6:0]};
      pbit     = 1'(($countones(exp_d) % 2)) ^ o;
      if ($urandom_range(0, 2) == 0) pbit = ~pbit;
      exp_perr = p && (1'(($countones(exp_d) + int'(pbit)) % 2) != o);
      exp_ovf  = model_rdy;
      send_char(val, e, p, o, pbit, stop_bit, -1);
      step(8);
      check_out($sformatf("rand%0d", i), exp_d, 1'b1, exp_perr, ~stop_bit, exp_ovf);
      model_rdy = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver for the UART top level: the counterpart of the transmit path on `tx`. Samples `rx` at mid-bit, deframes 7- or 8-bit characters with optional odd/even parity, and presents a byte plus status flags to the host side with a ready/read handshake. It is configured by the same `eight`, `pen`, `ohel` and `baud` controls as the transmitter and runs on the 50 MHz system clock.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency used to derive bit-time counts
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low; all state cleared while low
- `rx`  in  1  serial input, idle high, asynchronous to `clk`
- `eight`  in  1  1 = 8 data bits, 0 = 7 data bits
- `pen`  in  1  1 = parity bit present after data
- `ohel`  in  1  parity sense when `pen`=1: 1 = odd, 0 = even
- `baud`  in  4  bit-rate select (see Operation)
- `read`  in  1  one-cycle pulse from host; clears `rxrdy` and error flags
- `data`  out  8  received character, LSB = first data bit; bit 7 = 0 in 7-bit mode
- `rxrdy`  out  1  character available
- `perr`  out  1  parity error on current character
- `ferr`  out  1  framing error (stop bit sampled 0)
- `ovf`  out  1  overrun: character completed while `rxrdy` still set

## Operation
- Bit-time count N from `baud`: 0:300→166667, 1:1200→41667, 2:2400→20833, 3:4800→10417, 4:9600→5208, 5:19200→2604, 6:38400→1302, 7:57600→868, 8:115200→434, 9:230400→217, 10:460800→109, 11:921600→54, 12–15→434. Counter 18 bits.
- `rx` passes a 2-FF synchronizer (reset value 1); all decisions use the synchronized value.
- `eight`, `pen`, `ohel`, `baud` captured at start-bit detection; changes mid-frame affect the next frame only.
- States: IDLE, START, DATA, STOP.
  - IDLE: synchronized rx = 0 → START, counter cleared.
  - START: after N/2 (integer divide) cycles sample; 0 → DATA, 1 → false start, IDLE, no flags.
  - DATA: sample every N cycles; shift right into the data register; 7+`eight`+`pen` samples, the last being parity when `pen`=1 → STOP.
  - STOP: sample after N cycles; load outputs; → IDLE same cycle (mid-stop), allowing back-to-back frames.
- On load: `data` = received bits; `rxrdy`=1; `ferr` = (stop==0); `perr` = `pen` & (XOR(data bits, parity bit) != `ohel`); `ovf` = `rxrdy` was 1 and no `read` this cycle.
- `read` with no load: `rxrdy`, `perr`, `ferr`, `ovf` → 0; `data` holds.
- `read` coincident with load: load wins; new data, `rxrdy`=1, `ovf`=0.
- Framing error still delivers the character and returns to IDLE; a line held low re-arms only after rx returns high and falls again.

## Timing
- Reset values: `data`=0x00, `rxrdy`=`perr`=`ferr`=`ovf`=0, state IDLE.
- Start detect latency: 2 cycles after rx pin falls (synchronizer).
- Outputs registered; `rxrdy` rises the cycle after the stop-bit sample, ≈ 2 + N/2 + (bits+1)·N cycles after the start edge.
- Reset asserted mid-frame: immediate clear; after release, receiver waits for the next falling edge, partial frame discarded.

## Structure
- Shared package `uart_pkg`: baud-count constants and select-to-count function, state encoding, counter width. Shared with the transmitter.
- One sub-module `uart_bit_timer`: loadable down-counter with half/full-bit terminal-count pulse, reused by the transmitter.
- FSM, shift register, parity and flag logic live in `uart_rx`.

## Test plan
All at `baud`=11 (N=54, 1080 ns/bit).
- 8N1, send 0xA5, stop=1 → `data`=0xA5, `rxrdy`=1, `perr`=`ferr`=`ovf`=0; `read` pulse → `rxrdy`=0.
- 7E1 (`eight`=0,`pen`=1,`ohel`=0), send 0x41 with parity bit 1 → `data`=0x41, `perr`=1; repeat with parity 0 → `perr`=0.
- 8N1 0x3C with stop bit 0 → `data`=0x3C, `ferr`=1, `rxrdy`=1.
- rx low for 20 cycles then high → no `rxrdy`, FSM back in IDLE; following valid 0x55 frame received correctly.
- Two back-to-back 8N1 frames 0x11, 0x22, no `read` → `data`=0x22, `ovf`=1; `read` on the completion cycle instead → `ovf`=0.
- `reset` low during DATA of 0xFF, release, then send 0x0F → only 0x0F reported, flags clear.
